line_xfer_ctrl: RTL and testbench
=================================

# line_xfer_ctrl

Line-transfer controller sitting directly downstream of the 1024-set direct-mapped data cache, between it and main memory. It accepts whole-line write-back and refill requests from the cache, moves them as 16 sequential 64-bit beats over a single-word memory port, and returns the assembled refill line. Write-back-then-fill is one combined request, so a dirty miss costs one handshake.

## Interface
- `BLK_W`, 12: block address width ({tag[1:0], index[9:0]}).
- `WORDS`, 16: 64-bit words per line.
- `DATA_W`, 64: beat width.
- `MEM_LAT`, 4: fixed read latency of the memory port in cycles, ≥1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  cache request present.
- `req_ready`  out  1  controller can accept; high only in IDLE.
- `req_op`  in  2  01 fill, 10 write-back, 11 write-back then fill, 00 no-op.
- `req_fill_blk`  in  BLK_W  block to refill.
- `req_wb_blk`  in  BLK_W  victim block to write back.
- `req_wb_line`  in  WORDS*DATA_W  victim line data; word k is at [64k+63:64k].
- `resp_valid`  out  1  one-cycle pulse on request completion.
- `resp_filled`  out  1  qualifies `resp_line` (op had a fill).
- `resp_blk`  out  BLK_W  fill block of the completed request.
- `resp_line`  out  WORDS*DATA_W  refilled line, same word layout.
- `mem_en`  out  1  beat issued this cycle.
- `mem_we`  out  1  1 write, 0 read.
- `mem_addr`  out  BLK_W+4  word address {blk, k}.
- `mem_wdata`  out  DATA_W  write beat.
- `mem_rdata`  in  DATA_W  read beat.
- `mem_rvalid`  in  1  `mem_rdata` valid; in order, exactly MEM_LAT cycles after each read issue.

## Operation
- FSM states: IDLE, WB, FILL, DRAIN, RESP.
- IDLE: `req_ready`=1. Handshake = `req_valid && req_ready`. op 00 is never accepted; stays IDLE, no response. Accept captures op, both block addresses and `req_wb_line`, resets beat counters. Next state: WB for op 10/11, FILL for 01.
- WB: one write beat per cycle, k=0..15, `mem_addr`={wb_blk,k}, `mem_wdata`=word k of captured line. After k=15: FILL for op 11, RESP for op 10.
- FILL: one read beat per cycle, k=0..15, `mem_addr`={fill_blk,k}. `outstanding` increments on issue, decrements on `mem_rvalid`. After k=15 → DRAIN.
- Return collection runs in FILL and DRAIN: each `mem_rvalid` writes `mem_rdata` into word `ret_cnt`, then `ret_cnt`++. DRAIN → RESP on the cycle the 16th beat is captured.
- RESP: `resp_valid`=1 for one cycle; `resp_filled`=1 for ops 01/11. `resp_line` and `resp_blk` stay stable until the next accept. Next state: IDLE.
- `mem_rvalid` while `outstanding`==0 is ignored.
- Counters are 5 bits wide; `ret_cnt` never exceeds 16.

## Timing
- Reset values: `req_ready`=0 while `rst_n` is low, 1 after release (IDLE). All other outputs 0, `resp_line`=0, counters 0.
- Reset mid-transfer aborts immediately with no response. Memory shares `rst_n` and drops in-flight reads.
- Request accepted at edge T. Beats are issued on the cycles after T.
- Op 10: writes T+1..T+16, `resp_valid` at T+17, `req_ready` again at T+18.
- Op 01: reads T+1..T+16, returns T+1+MEM_LAT..T+16+MEM_LAT, `resp_valid` at T+17+MEM_LAT (T+21 at default).
- Op 11: writes T+1..T+16, reads T+17..T+32, `resp_valid` at T+33+MEM_LAT.
- Write beats never overlap read beats; `mem_en` is never high with `mem_we` toggling within a phase.
- `req_ready` is 0 in the `resp_valid` cycle, so no back-to-back accept.

## Structure
- Package `line_xfer_pkg`: op encodings (OP_NOP, OP_FILL, OP_WB, OP_WBFILL), state enum, DATA_W/WORDS/LINE_W/BLK_W constants shared with the cache.
- One sub-module, `line_buffer`: a LINE_W register with indexed beat write (fill) and indexed beat read (write-back), plus parallel load/readout.

## Test plan
- Fill-only, fill_blk=12'h3A5, memory word = {blk,k} pattern → reads addressed 16'h3A50..3A5F at T+1..T+16; `resp_valid` at T+21; `resp_line` word 7 = pattern(0x3A57).
- Write-back-only, wb_blk=12'h001, line words = k+100 → writes at T+1..T+16 with `mem_addr`=0x0010+k and `mem_wdata`=k+100; `resp_valid` at T+17 with `resp_filled`=0.
- Combined op 11, wb_blk=0x801, fill_blk=0xC01 → 16 writes, then 16 reads; `resp_valid` at T+37; memory at 0x8010..0x801F is updated before the refill.
- `req_valid` held high with op 00, then a stray `mem_rvalid` in IDLE → no accept, no response, `ret_cnt` stays 0.
- `rst_n` pulled low at T+8 of a fill, then released → all outputs 0; the next fill request completes with a correct line and no stale beats.
- MEM_LAT=1 parameter sweep → fill `resp_valid` at T+18; back-to-back requests are spaced by the RESP+IDLE cycles.

Source files
------------

// File: rtl/line_xfer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : line_xfer_pkg
// Brief    : Shared constants, request opcodes and controller states for the
//            cache line-transfer controller.
// Revision : 1.0 - initial release
// ============================================================================
package line_xfer_pkg;

  localparam int DATA_W      = 64;              // memory beat width
  localparam int WORDS       = 16;              // beats per cache line
  localparam int LINE_W      = WORDS * DATA_W;  // full line width
  localparam int BLK_W       = 12;              // {tag[1:0], index[9:0]}
  localparam int CNT_W       = 5;               // beat / return / outstanding counters
  localparam int MEM_LAT_DEF = 4;               // default memory read latency

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_FILL   = 2'b01,
    OP_WB     = 2'b10,
    OP_WBFILL = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WB    = 3'd1,
    ST_FILL  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // Bit 1 of the opcode selects the write-back phase
  function automatic logic op_has_wb(input op_e op);
    return op[1];
  endfunction

  // Bit 0 of the opcode selects the refill phase
  function automatic logic op_has_fill(input op_e op);
    return op[0];
  endfunction

endpackage : line_xfer_pkg
`default_nettype wire

// File: rtl/line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : line_buffer
// Brief    : One cache line of storage. Loaded in parallel with the victim
//            line, read beat-by-beat for write-back, written beat-by-beat by
//            refill returns, and presented in full as the response line.
// Revision : 1.0 - initial release
// ============================================================================
module line_buffer #(
  parameter int WORDS  = line_xfer_pkg::WORDS,
  parameter int DATA_W = line_xfer_pkg::DATA_W,
  parameter int IDX_W  = $clog2(WORDS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_i,
  input  logic [WORDS*DATA_W-1:0] load_line_i,
  input  logic                    wr_en_i,
  input  logic [IDX_W-1:0]        wr_idx_i,
  input  logic [DATA_W-1:0]       wr_data_i,
  input  logic [IDX_W-1:0]        rd_idx_i,
  output logic [DATA_W-1:0]       rd_data_o,
  output logic [WORDS*DATA_W-1:0] line_o
);

  import line_xfer_pkg::*;

  for (genvar w = 0; w < WORDS; w++) begin : g_word
    logic [DATA_W-1:0] word_q;

    // Parallel load on accept wins over a refill beat aimed at this word
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        word_q <= '0;
      end else if (load_i) begin
        word_q <= load_line_i[w*DATA_W +: DATA_W];
      end else if (wr_en_i && (wr_idx_i == IDX_W'(w))) begin
        word_q <= wr_data_i;
      end
    end

    assign line_o[w*DATA_W +: DATA_W] = word_q;
  end

  assign rd_data_o = line_o[rd_idx_i*DATA_W +: DATA_W];

endmodule : line_buffer
`default_nettype wire

// File: rtl/line_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : line_xfer_ctrl
// Brief    : Moves whole cache lines between the data cache and a single-word
//            memory port: write-back, refill, or write-back followed by
//            refill, as 16 sequential beats each.
// Revision : 1.0 - initial release
// ============================================================================
module line_xfer_ctrl #(
  parameter int BLK_W   = line_xfer_pkg::BLK_W,
  parameter int WORDS   = line_xfer_pkg::WORDS,
  parameter int DATA_W  = line_xfer_pkg::DATA_W,
  parameter int MEM_LAT = line_xfer_pkg::MEM_LAT_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [1:0]                        req_op,
  input  logic [BLK_W-1:0]                  req_fill_blk,
  input  logic [BLK_W-1:0]                  req_wb_blk,
  input  logic [WORDS*DATA_W-1:0]           req_wb_line,
  output logic                              resp_valid,
  output logic                              resp_filled,
  output logic [BLK_W-1:0]                  resp_blk,
  output logic [WORDS*DATA_W-1:0]           resp_line,
  output logic                              mem_en,
  output logic                              mem_we,
  output logic [BLK_W+$clog2(WORDS)-1:0]    mem_addr,
  output logic [DATA_W-1:0]                 mem_wdata,
  input  logic [DATA_W-1:0]                 mem_rdata,
  input  logic                              mem_rvalid
);

  import line_xfer_pkg::*;

  localparam int IDX_W = $clog2(WORDS);

  // The controller is latency-agnostic; the read latency only has to be real
  if (MEM_LAT < 1) begin : g_mem_lat_check
    $error("line_xfer_ctrl: MEM_LAT must be at least 1");
  end

  state_e           state_q, state_d;
  op_e              op_q;
  logic [BLK_W-1:0] wb_blk_q, fill_blk_q;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic [CNT_W-1:0] outst_q, outst_d;

  logic              accept;
  logic              ret_take;
  logic              rd_issue;
  logic              last_beat;
  logic [DATA_W-1:0] wb_word;

  assign accept    = (state_q == ST_IDLE) && req_valid && (req_op != OP_NOP);
  // Returns are only meaningful while a refill has reads in flight
  assign ret_take  = mem_rvalid && (outst_q != '0) &&
                     ((state_q == ST_FILL) || (state_q == ST_DRAIN));
  assign last_beat = (beat_q == CNT_W'(WORDS - 1));

  // State register and beat/return/outstanding counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      ret_q   <= '0;
      outst_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      ret_q   <= ret_d;
      outst_q <= outst_d;
    end
  end

  // Request fields captured at accept and held until the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= OP_NOP;
      wb_blk_q   <= '0;
      fill_blk_q <= '0;
    end else if (accept) begin
      op_q       <= op_e'(req_op);
      wb_blk_q   <= req_wb_blk;
      fill_blk_q <= req_fill_blk;
    end
  end

  // Next-state, counter updates and memory-port drive
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    ret_d     = ret_q;
    rd_issue  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    if (ret_take) begin
      ret_d = ret_q + CNT_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          beat_d  = '0;
          ret_d   = '0;
          state_d = op_has_wb(op_e'(req_op)) ? ST_WB : ST_FILL;
        end
      end
      ST_WB: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {wb_blk_q, beat_q[IDX_W-1:0]};
        mem_wdata = wb_word;
        if (last_beat) begin
          beat_d  = '0;
          state_d = op_has_fill(op_q) ? ST_FILL : ST_RESP;
        end else begin
          beat_d = beat_q + CNT_W'(1);
        end
      end
      ST_FILL: begin
        mem_en   = 1'b1;
        rd_issue = 1'b1;
        mem_addr = {fill_blk_q, beat_q[IDX_W-1:0]};
        if (last_beat) begin
          beat_d  = '0;
          state_d = ST_DRAIN;
        end else begin
          beat_d = beat_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (ret_take && (ret_q == CNT_W'(WORDS - 1))) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    outst_d = outst_q + CNT_W'(rd_issue) - CNT_W'(ret_take);
  end

  line_buffer #(
    .WORDS  (WORDS),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_line_buffer (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (accept),
    .load_line_i (req_wb_line),
    .wr_en_i     (ret_take),
    .wr_idx_i    (ret_q[IDX_W-1:0]),
    .wr_data_i   (mem_rdata),
    .rd_idx_i    (beat_q[IDX_W-1:0]),
    .rd_data_o   (wb_word),
    .line_o      (resp_line)
  );

  // Ready is held low for as long as reset is asserted
  assign req_ready   = rst_n && (state_q == ST_IDLE);
  assign resp_valid  = (state_q == ST_RESP);
  assign resp_filled = resp_valid && op_has_fill(op_q);
  assign resp_blk    = fill_blk_q;

endmodule : line_xfer_ctrl
`default_nettype wire

// File: tb/tb_line_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_xfer_ctrl
// Brief    : Self-checking bench for line_xfer_ctrl with a latency-configurable
//            memory model, a request-level reference model and a vector table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_xfer_ctrl;

  localparam int LW = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = 2'b00;
  logic [11:0]   req_fill_blk = '0;
  logic [11:0]   req_wb_blk = '0;
  logic [LW-1:0] req_wb_line = '0;
  logic          resp_valid;
  logic          resp_filled;
  logic [11:0]   resp_blk;
  logic [LW-1:0] resp_line;
  logic          mem_en;
  logic          mem_we;
  logic [15:0]   mem_addr;
  logic [63:0]   mem_wdata;
  logic [63:0]   mem_rdata = '0;
  logic          mem_rvalid = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lat = 4;
  bit stray_req = 1'b0;

  always #5 clk = ~clk;

  line_xfer_ctrl #(.BLK_W(12), .WORDS(16), .DATA_W(64), .MEM_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_fill_blk(req_fill_blk), .req_wb_blk(req_wb_blk), .req_wb_line(req_wb_line),
    .resp_valid(resp_valid), .resp_filled(resp_filled), .resp_blk(resp_blk),
    .resp_line(resp_line),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  // ---------------- memory model ----------------
  typedef struct { int due; logic [63:0] d; } rd_t;
  typedef struct { int cyc; logic we; logic [15:0] addr; logic [63:0] d; } beat_t;

  logic [63:0] mem [int];
  rd_t         rq[$];
  beat_t       trace[$];
  logic        s_en = 1'b0, s_we = 1'b0;
  logic [15:0] s_addr = '0;
  logic [63:0] s_wdata = '0;

  function automatic logic [63:0] pat(input logic [15:0] a);
    return {a, ~a, a ^ 16'hA5C3, a + 16'd1};
  endfunction

  function automatic logic [63:0] mem_rd(input logic [15:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return pat(a);
  endfunction

  always @(negedge clk) begin
    s_en = mem_en; s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata;
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      rq.delete();
    end else if (s_en) begin
      trace.push_back('{cyc, s_we, s_addr, s_wdata});
      if (s_we) mem[int'(s_addr)] = s_wdata;
      else      rq.push_back('{cyc + lat, mem_rd(s_addr)});
    end
    #1;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (rst_n && rq.size() > 0 && rq[0].due == cyc + 1) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rq[0].d;
      void'(rq.pop_front());
    end else if (stray_req) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_line(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    int idx = 0;
    for (int k = 15; k >= 0; k--) if (got[k*64 +: 64] !== exp[k*64 +: 64]) idx = k;
    chk($sformatf("%s[w%0d]", name, idx), got[idx*64 +: 64], exp[idx*64 +: 64]);
  endtask

  // Completion latency derived from the phase rules: 16 beats per phase,
  // plus the read latency when a refill is involved, plus the RESP cycle.
  function automatic int ref_lat(input logic [1:0] op, input int l);
    return 1 + (op[1] ? 16 : 0) + (op[0] ? 16 + l : 0);
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL wait_ready: got 0 expected 1 within 100 cycles");
    end
  endtask

  // One full request with scoreboard checks on response, beats and memory
  task automatic do_req(input logic [1:0] op, input logic [11:0] fb, input logic [11:0] wb,
                        input logic [31:0] seed, input int lat_i, input int exp_lat,
                        input logic exp_filled, output int t_acc, output int t_resp,
                        output logic [LW-1:0] got_line);
    logic [LW-1:0] wline, eline;
    int tstart, n, nwb, bad;
    bit seen;
    logic ewe; logic [15:0] eaddr; logic [63:0] ed;
    for (int k = 0; k < 16; k++) wline[k*64 +: 64] = {seed, 32'(k + 100)};
    for (int k = 0; k < 16; k++)
      eline[k*64 +: 64] = (op[1] && wb == fb) ? wline[k*64 +: 64] : mem_rd({fb, 4'(k)});
    got_line = '0; t_resp = -1;
    wait_ready();
    lat = lat_i;
    req_op = op; req_fill_blk = fb; req_wb_blk = wb; req_wb_line = wline; req_valid = 1'b1;
    tstart = trace.size();
    @(negedge clk);
    t_acc = cyc;
    req_valid = 1'b0; req_op = 2'b00;
    chk("accepted", req_ready, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (resp_valid) begin seen = 1'b1; t_resp = cyc + 1; end
      else @(negedge clk);
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL resp_timeout: got no resp_valid expected one within 200 cycles");
      return;
    end
    got_line = resp_line;
    chk("latency", t_resp - t_acc, exp_lat);
    chk("resp_filled", resp_filled, exp_filled);
    chk("resp_blk", resp_blk, fb);
    chk("ready_in_resp", req_ready, 1'b0);
    if (op[0]) chk_line("resp_line", resp_line, eline);
    @(negedge clk);
    chk("resp_pulse", resp_valid, 1'b0);
    chk("ready_after", req_ready, 1'b1);
    if (op[0]) chk_line("resp_hold", resp_line, eline);
    nwb = op[1] ? 16 : 0;
    n = nwb + (op[0] ? 16 : 0);
    bad = -1;
    for (int i = 0; i < n; i++) begin
      ewe   = (i < nwb);
      eaddr = ewe ? {wb, 4'(i)} : {fb, 4'(i - nwb)};
      ed    = ewe ? wline[i*64 +: 64] : 64'h0;
      if (tstart + i >= trace.size()) begin
        if (bad < 0) bad = i;
      end else if (trace[tstart+i].cyc != t_acc + 1 + i || trace[tstart+i].we !== ewe ||
                   trace[tstart+i].addr !== eaddr || (ewe && trace[tstart+i].d !== ed)) begin
        if (bad < 0) bad = i;
      end
    end
    chk("beat_count", trace.size() - tstart, n);
    chk("beat_first_bad", bad, -1);
    if (op[1]) begin
      bad = -1;
      for (int k = 15; k >= 0; k--) if (mem_rd({wb, 4'(k)}) !== wline[k*64 +: 64]) bad = k;
      chk("wb_mem_first_bad", bad, -1);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  op;
    logic [11:0] fb;
    logic [11:0] wb;
    logic [31:0] seed;
    int          lat;
    int          exp_lat;
    logic        exp_filled;
  } vec_t;

  vec_t          vt[6];
  logic [LW-1:0] vline[6];

  initial begin : main
    int ta, tr, ta2, tr2;
    logic [LW-1:0] gl;
    logic [1:0] rop;

    vt[0] = '{2'b01, 12'h3A5, 12'h000, 32'h0000_0000, 4, 21, 1'b1};
    vt[1] = '{2'b10, 12'h000, 12'h001, 32'h0000_0000, 4, 17, 1'b0};
    vt[2] = '{2'b11, 12'hC01, 12'h801, 32'h1111_2222, 4, 37, 1'b1};
    vt[3] = '{2'b01, 12'h3A5, 12'h000, 32'h0000_0000, 1, 18, 1'b1};
    vt[4] = '{2'b11, 12'h123, 12'h123, 32'h5555_AAAA, 1, 34, 1'b1};
    vt[5] = '{2'b10, 12'h0F0, 12'hFFF, 32'hCAFE_F00D, 1, 17, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk_line("rst_resp_line", resp_line, '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", req_ready, 1'b1);

    // Table-driven requests
    for (int i = 0; i < 6; i++) begin
      do_req(vt[i].op, vt[i].fb, vt[i].wb, vt[i].seed, vt[i].lat, vt[i].exp_lat,
             vt[i].exp_filled, ta, tr, gl);
      vline[i] = gl;
    end
    chk("fill_word7", vline[0][7*64 +: 64], pat(16'h3A57));
    chk("wb_word3_addr", mem_rd(16'h0013), 64'd103);

    // Op 00 held with valid, plus a stray return in IDLE
    req_valid = 1'b1; req_op = 2'b00; req_fill_blk = 12'h0AA;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("nop_ready", req_ready, 1'b1);
      chk("nop_resp", resp_valid, 1'b0);
      chk("nop_mem_en", mem_en, 1'b0);
    end
    stray_req = 1'b1;
    @(posedge clk); #2;
    stray_req = 1'b0;
    repeat (2) @(negedge clk);
    req_valid = 1'b0;
    chk("stray_resp", resp_valid, 1'b0);
    do_req(2'b01, 12'h0AA, 12'h000, 32'h0, 4, 21, 1'b1, ta, tr, gl);

    // Reset in the middle of a fill, then a clean fill of the same block
    wait_ready();
    lat = 4;
    req_op = 2'b01; req_fill_blk = 12'h2B7; req_valid = 1'b1;
    @(negedge clk);
    ta = cyc;
    req_valid = 1'b0; req_op = 2'b00;
    while (cyc < ta + 7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ready", req_ready, 1'b0);
    chk("midrst_resp_valid", resp_valid, 1'b0);
    chk("midrst_mem_en", mem_en, 1'b0);
    chk("midrst_resp_blk", resp_blk, 12'h000);
    chk_line("midrst_resp_line", resp_line, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_req(2'b01, 12'h2B7, 12'h000, 32'h0, 4, 21, 1'b1, ta, tr, gl);

    // Back-to-back requests at latency 1: one IDLE cycle after RESP
    do_req(2'b01, 12'h444, 12'h000, 32'h0, 1, 18, 1'b1, ta, tr, gl);
    do_req(2'b10, 12'h445, 12'h446, 32'h77, 1, 17, 1'b0, ta2, tr2, gl);
    chk("b2b_gap", ta2 - tr, 1);

    // Randomized requests against the reference model
    for (int i = 0; i < 10; i++) begin
      int l;
      rop = 2'($urandom_range(1, 3));
      l   = int'($urandom_range(1, 6));
      do_req(rop, 12'($urandom), 12'($urandom), $urandom, l, ref_lat(rop, l), rop[0],
             ta, tr, gl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

endmodule : tb_line_xfer_ctrl
`default_nettype wire
